// File: rtl/sar_div_pkg.sv
// Shared types and constants for the round-robin front end of the iterative SAR divider.
package sar_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_t;

  localparam int BITS_DEFAULT = 40;

  // Wide enough for any supported BITS; truncate at the point of use.
  localparam logic [63:0] DZ_RESULT = '1;

endpackage

// File: rtl/sar_divider_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, searching cyclically.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            grant_any,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IW-1:0]   grant_idx
);

  logic [IW:0] cand;

  // NOTE: every output gets a default before the loop, so no path leaves a value held and no latch is inferred.
  always_comb begin
    grant_any    = 1'b0;
    grant_onehot = '0;
    grant_idx    = '0;
    cand         = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!grant_any && req[cand[IW-1:0]]) begin
        grant_any                   = 1'b1;
        grant_onehot[cand[IW-1:0]] = 1'b1;
        grant_idx                   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sar_divider_arbiter.sv
// Shares one iterative SAR divider among NREQ requesters, round-robin, one operation at a time.
// Optional: define SAR_DIV_ZERO_BYPASS_EN to answer divisor==0 directly without using the divider.
module sar_divider_arbiter
  import sar_div_pkg::*;
#(
  parameter int BITS         = BITS_DEFAULT,
  parameter int NREQ         = 4,
  parameter int START_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BITS-1:0] req_dividend,
  input  logic [NREQ*BITS-1:0] req_divisor,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [BITS-1:0]      rsp_result,
  output logic                 rsp_dz,
  output logic [BITS-1:0]      div_dividendo,
  output logic [BITS-1:0]      div_divisor,
  output logic                 div_reset,
  input  logic [BITS-1:0]      div_result,
  input  logic                 div_ready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant_q;
  logic [CW-1:0]   load_cnt;
  logic            run_first;

  logic            grant_any;
  logic [NREQ-1:0] grant_onehot;
  logic [IW-1:0]   grant_idx;
  logic [BITS-1:0] sel_dividend;
  logic [BITS-1:0] sel_divisor;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req          (req_valid),
    .ptr          (rr_ptr),
    .grant_any    (grant_any),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  assign sel_dividend = req_dividend[grant_idx*BITS +: BITS];
  assign sel_divisor  = req_divisor[grant_idx*BITS +: BITS];

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_q       <= '0;
      load_cnt      <= '0;
      run_first     <= 1'b0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
`ifdef SAR_DIV_ZERO_BYPASS_EN
      rsp_dz        <= 1'b0;
`endif
      div_reset     <= 1'b1;
      div_dividendo <= '0;
      div_divisor   <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            req_ready <= grant_onehot;
            grant_q   <= grant_idx;
            rr_ptr    <= (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            load_cnt  <= '0;
`ifdef SAR_DIV_ZERO_BYPASS_EN
            if (sel_divisor == '0) begin
              state <= RESP;
            end else begin
              div_dividendo <= sel_dividend;
              div_divisor   <= sel_divisor;
              state         <= LOAD;
            end
`else
            div_dividendo <= sel_dividend;
            div_divisor   <= sel_divisor;
            state         <= LOAD;
`endif
          end
        end
        LOAD: begin
          if (load_cnt == CW'(START_CYCLES-1)) begin
            div_reset <= 1'b0;
            run_first <= 1'b1;
            state     <= RUN;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        RUN: begin
          // A done flag left over from the previous run may still be high in the first cycle.
          if (run_first) begin
            run_first <= 1'b0;
          end else if (div_ready) begin
            rsp_result <= div_result;
            rsp_valid  <= NREQ'(1) << grant_q;
`ifdef SAR_DIV_ZERO_BYPASS_EN
            rsp_dz     <= 1'b0;
`endif
            div_reset  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
`ifdef SAR_DIV_ZERO_BYPASS_EN
          if (rsp_valid == '0) begin
            rsp_valid  <= NREQ'(1) << grant_q;
            rsp_result <= BITS'(DZ_RESULT);
            rsp_dz     <= 1'b1;
          end else if (rsp_ready[grant_q]) begin
            rsp_valid <= '0;
            div_reset <= 1'b1;
            state     <= IDLE;
          end
`else
          if (rsp_ready[grant_q]) begin
            rsp_valid <= '0;
            div_reset <= 1'b1;
            state     <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SAR_DIV_ZERO_BYPASS_EN
  assign rsp_dz = 1'b0;
`endif

endmodule

// File: tb/tb_sar_divider_arbiter.sv
// Directed bench for sar_divider_arbiter with a behavioural iterative-divider model.
module tb_sar_divider_arbiter;

  localparam int BITS    = 40;
  localparam int NREQ    = 4;
  localparam int START   = 2;
  localparam int RUN_LAT = 8;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BITS-1:0] req_dividend;
  logic [NREQ*BITS-1:0] req_divisor;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [BITS-1:0]      rsp_result;
  logic                 rsp_dz;
  logic [BITS-1:0]      div_dividendo;
  logic [BITS-1:0]      div_divisor;
  logic                 div_reset;
  logic [BITS-1:0]      div_result;
  logic                 div_ready;

  int total;
  int bad;
  int model_cnt;
  bit stale_mode;

  typedef struct {
    int              r;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS-1:0] q;
  } vec_t;

  vec_t vecs[6];
  int   fair_q[4];

  sar_divider_arbiter #(.BITS(BITS), .NREQ(NREQ), .START_CYCLES(START)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_dz        (rsp_dz),
    .div_dividendo (div_dividendo),
    .div_divisor   (div_divisor),
    .div_reset     (div_reset),
    .div_result    (div_result),
    .div_ready     (div_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: counts cycles since div_reset fell, done after RUN_LAT; optional stale done in cycle 1.
  initial begin
    model_cnt  = 0;
    div_ready  = 1'b0;
    div_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || div_reset) begin
        model_cnt  = 0;
        div_ready  = 1'b0;
        div_result = '0;
      end else begin
        model_cnt++;
        if (stale_mode && model_cnt == 1) begin
          div_ready  = 1'b1;
          div_result = 40'hDE_AD00_BEEF;
        end else if (model_cnt >= RUN_LAT) begin
          div_ready  = 1'b1;
          div_result = (div_divisor == '0) ? '1 : div_dividendo / div_divisor;
        end else begin
          div_ready  = 1'b0;
          div_result = '0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input int r, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       input bit keep);
    int n;
    req_dividend[r*BITS +: BITS] = a;
    req_divisor[r*BITS +: BITS]  = b;
    req_valid[r] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 100);
    check("grant", 64'(req_ready), 64'(NREQ'(1) << r));
    if (!keep) req_valid[r] = 1'b0;
  endtask

  task automatic wait_load(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    int n;
    check("div_dividendo", 64'(div_dividendo), 64'(a));
    check("div_divisor", 64'(div_divisor), 64'(b));
    n = 0;
    while (div_reset === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("load_cycles", 64'(n), 64'(START));
  endtask

  task automatic wait_rsp(input int r, input logic [BITS-1:0] q, input logic dz);
    int n;
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid", 64'(rsp_valid), 64'(NREQ'(1) << r));
    check("rsp_result", 64'(rsp_result), 64'(q));
    check("rsp_dz", 64'(rsp_dz), 64'(dz));
    check("div_reset_in_resp", 64'(div_reset), 64'(1));
  endtask

  task automatic handshake(input int r);
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready[r] = 1'b0;
    check("rsp_cleared", 64'(rsp_valid), 64'(0));
  endtask

  task automatic run_txn(input int r, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input logic [BITS-1:0] q, input logic dz, input bit keep);
    issue(r, a, b, keep);
    wait_load(a, b);
    wait_rsp(r, q, dz);
    handshake(r);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_rsp_result"}, 64'(rsp_result), 64'(0));
    check({tag, "_rsp_dz"}, 64'(rsp_dz), 64'(0));
    check({tag, "_div_reset"}, 64'(div_reset), 64'(1));
    check({tag, "_div_dividendo"}, 64'(div_dividendo), 64'(0));
    check({tag, "_div_divisor"}, 64'(div_divisor), 64'(0));
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    stale_mode   = 1'b0;
    reset        = 1'b1;
    req_valid    = '0;
    rsp_ready    = '0;
    req_dividend = '0;
    req_divisor  = '0;

    vecs[0] = '{r: 0, a: 40'd425_332_234,     b: 40'd62_254, q: 40'd6832};
    vecs[1] = '{r: 1, a: 40'd1000,            b: 40'd7,      q: 40'd142};
    vecs[2] = '{r: 2, a: 40'hFF_FFFF_FFFF,    b: 40'd1,      q: 40'hFF_FFFF_FFFF};
    vecs[3] = '{r: 3, a: 40'd5,               b: 40'd9,      q: 40'd0};
    vecs[4] = '{r: 1, a: 40'd123_456_789_012, b: 40'd1000,   q: 40'd123_456_789};
    vecs[5] = '{r: 2, a: 40'd81,              b: 40'd81,     q: 40'd1};
    fair_q  = '{100, 50, 33, 25};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].q, 1'b0, 1'b0);

    // A done flag raised in the first run cycle must not be taken as the result.
    stale_mode = 1'b1;
    run_txn(3, 40'd1000, 40'd10, 40'd100, 1'b0, 1'b0);
    stale_mode = 1'b0;

    // Response backpressure with a competing request and a stray rsp_ready on another line.
    issue(1, 40'd90, 40'd9, 1'b0);
    req_dividend[0*BITS +: BITS] = 40'd77;
    req_divisor[0*BITS +: BITS]  = 40'd7;
    req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    wait_load(40'd90, 40'd9);
    wait_rsp(1, 40'd10, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
      check("bp_rsp_result", 64'(rsp_result), 64'(10));
      check("bp_no_grant", 64'(req_ready), 64'(0));
      check("bp_div_reset", 64'(div_reset), 64'(1));
    end
    rsp_ready[0] = 1'b0;
    handshake(1);
    run_txn(0, 40'd77, 40'd7, 40'd11, 1'b0, 1'b0);

`ifdef SAR_DIV_ZERO_BYPASS_EN
    issue(2, 40'd7, 40'd0, 1'b0);
    check("dz_no_rsp_yet", 64'(rsp_valid), 64'(0));
    check("dz_div_reset_a", 64'(div_reset), 64'(1));
    @(negedge clk);
    check("dz_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check("dz_rsp_result", 64'(rsp_result), 64'(40'hFF_FFFF_FFFF));
    check("dz_rsp_dz", 64'(rsp_dz), 64'(1));
    check("dz_div_reset_b", 64'(div_reset), 64'(1));
    handshake(2);
`else
    run_txn(2, 40'd7, 40'd0, 40'hFF_FFFF_FFFF, 1'b0, 1'b0);
`endif

    // Reset in the middle of a run drops the operation and restarts the pointer.
    issue(1, 40'd500, 40'd5, 1'b0);
    wait_load(40'd500, 40'd5);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("midrun");
    @(negedge clk);
    check("midrun_no_rsp", 64'(rsp_valid), 64'(0));
    reset = 1'b0;
    req_dividend[2*BITS +: BITS] = 40'd60;
    req_divisor[2*BITS +: BITS]  = 40'd6;
    req_valid[2] = 1'b1;
    run_txn(0, 40'd45, 40'd9, 40'd5, 1'b0, 1'b0);
    run_txn(2, 40'd60, 40'd6, 40'd10, 1'b0, 1'b0);

    // Fairness from a fresh pointer with every requester asserting.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*BITS +: BITS] = 40'd100;
      req_divisor[i*BITS +: BITS]  = BITS'(i + 1);
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++)
      run_txn(k % 4, 40'd100, BITS'(k % 4 + 1), BITS'(fair_q[k % 4]), 1'b0, 1'b1);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("idle_after_fair", 64'(req_ready), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
